sens_frame_progress: RTL and testbench

SENS_FRAME_PROGRESS -- requirements
Module: sens_frame_progress

---
 rtl/sens_frame_progress_pkg.sv | 23 ++
 rtl/sens_frame_progress.sv | 179 +++++++++++++++++
 tb/tb_sens_frame_progress.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sens_frame_progress_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sens_frame_progress_pkg
// Description : Shared sensor/compressor frame-sync definitions: channel state
//               encodings and default counter widths used by both ends.
// Revision    : 1.0 - initial release
// ============================================================================
package sens_frame_progress_pkg;

  // Channel state encoding shared by the sensor writer and the compressor
  typedef enum logic [1:0] {
    SFP_IDLE       = 2'd0,
    SFP_WAIT_START = 2'd1,
    SFP_ACTIVE     = 2'd2
  } sfp_state_t;

  // Default line counter width
  localparam int SFP_FRAME_HEIGHT_BITS = 16;
  // Default frame buffer index width
  localparam int SFP_LAST_FRAME_BITS   = 16;

endpackage : sens_frame_progress_pkg
`default_nettype wire

// File: rtl/sens_frame_progress.sv
`default_nettype none
// ============================================================================
// Module      : sens_frame_progress
// Description : Tracks sensor frame write progress: completed line index,
//               frame buffer index, end-of-frame and delayed vsync pulses,
//               busy flag and overrun detection.
// Revision    : 1.0 - initial release
// ============================================================================
module sens_frame_progress
  import sens_frame_progress_pkg::*;
#(
  parameter int FRAME_HEIGHT_BITS = SFP_FRAME_HEIGHT_BITS,
  parameter int LAST_FRAME_BITS   = SFP_LAST_FRAME_BITS
) (
  input  logic                         mclk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         frame_start,
  input  logic                         line_done,
  input  logic [FRAME_HEIGHT_BITS-1:0] frame_height,
  input  logic [FRAME_HEIGHT_BITS-1:0] vsync_delay,
  input  logic [LAST_FRAME_BITS-1:0]   last_frame_number,
  input  logic                         single_frame_buf,
  output logic [FRAME_HEIGHT_BITS-1:0] line_unfinished,
  output logic [LAST_FRAME_BITS-1:0]   frame_number,
  output logic                         frame_done,
  output logic                         vsync_late,
  output logic                         frame_busy,
  output logic                         frame_overrun
);

  sfp_state_t state, state_next;

  // Configuration captured at each accepted frame_start
  logic [FRAME_HEIGHT_BITS-1:0] height_q;
  logic [FRAME_HEIGHT_BITS-1:0] vdelay_q;
  logic [LAST_FRAME_BITS-1:0]   last_q;
  logic                         single_q;

  // vsync_late still owed for the current frame; done_req delays frame_done
  logic vs_armed;
  logic done_req;

  logic                         start_ok;
  logic                         accept_start;
  logic                         restart;
  logic                         accept_line;
  logic                         last_line;
  logic [FRAME_HEIGHT_BITS-1:0] line_next;
  logic [FRAME_HEIGHT_BITS-1:0] vs_thr;
  logic [LAST_FRAME_BITS-1:0]   fn_next;
  logic                         vs_fire;

  // Zero-height frames are treated as if no frame_start arrived
  assign start_ok  = frame_start && (frame_height != '0);
  assign line_next = line_unfinished + 1'b1;

  // vsync threshold, buffer index successor and vsync trigger
  always_comb begin
    vs_thr = (vdelay_q < height_q) ? vdelay_q : height_q;
    fn_next = frame_number + 1'b1;
    if (single_q || (frame_number >= last_q)) begin
      fn_next = '0;
    end
    vs_fire = vs_armed && (line_unfinished == vs_thr);
  end

  // State register
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SFP_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and event strobes; frame_start beats line_done, en beats all
  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    restart      = 1'b0;
    accept_line  = 1'b0;
    last_line    = 1'b0;
    if (!en) begin
      state_next = SFP_IDLE;
    end else begin
      case (state)
        SFP_IDLE: begin
          state_next = SFP_WAIT_START;
        end
        SFP_WAIT_START: begin
          if (start_ok) begin
            accept_start = 1'b1;
            state_next   = SFP_ACTIVE;
          end
        end
        SFP_ACTIVE: begin
          if (start_ok) begin
            accept_start = 1'b1;
            restart      = 1'b1;
          end else if (line_done && (line_unfinished < height_q)) begin
            accept_line = 1'b1;
            if (line_next == height_q) begin
              last_line  = 1'b1;
              state_next = SFP_WAIT_START;
            end
          end
        end
        default: begin
          state_next = SFP_IDLE;
        end
      endcase
    end
  end

  // Counters, latched configuration and output pulses
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      height_q        <= '0;
      vdelay_q        <= '0;
      last_q          <= '0;
      single_q        <= 1'b0;
      vs_armed        <= 1'b0;
      done_req        <= 1'b0;
      line_unfinished <= '0;
      frame_number    <= '0;
      frame_done      <= 1'b0;
      vsync_late      <= 1'b0;
      frame_busy      <= 1'b0;
      frame_overrun   <= 1'b0;
    end else if (!en) begin
      height_q        <= '0;
      vdelay_q        <= '0;
      last_q          <= '0;
      single_q        <= 1'b0;
      vs_armed        <= 1'b0;
      done_req        <= 1'b0;
      line_unfinished <= '0;
      frame_number    <= '0;
      frame_done      <= 1'b0;
      vsync_late      <= 1'b0;
      frame_busy      <= 1'b0;
      frame_overrun   <= 1'b0;
    end else begin
      frame_done    <= done_req;
      done_req      <= 1'b0;
      frame_overrun <= 1'b0;
      vsync_late    <= 1'b0;
      if (vs_fire) begin
        vsync_late <= 1'b1;
        vs_armed   <= 1'b0;
      end
      if (accept_start) begin
        height_q        <= frame_height;
        vdelay_q        <= vsync_delay;
        last_q          <= last_frame_number;
        single_q        <= single_frame_buf;
        line_unfinished <= '0;
        frame_busy      <= 1'b1;
        vs_armed        <= 1'b1;
        frame_overrun   <= restart;
        // A vsync still owed by an aborted frame is dropped
        if (restart) begin
          vsync_late <= 1'b0;
        end
      end
      if (accept_line) begin
        line_unfinished <= line_next;
        if (last_line) begin
          frame_number <= fn_next;
          frame_busy   <= 1'b0;
          done_req     <= 1'b1;
        end
      end
    end
  end

endmodule : sens_frame_progress
`default_nettype wire

// File: tb/tb_sens_frame_progress.sv
`default_nettype none
// ============================================================================
// Module      : tb_sens_frame_progress
// Description : Directed self-checking bench for sens_frame_progress.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sens_frame_progress;

  logic        mclk;
  logic        rst_n;
  logic        en;
  logic        frame_start;
  logic        line_done;
  logic [15:0] frame_height;
  logic [15:0] vsync_delay;
  logic [15:0] last_frame_number;
  logic        single_frame_buf;
  logic [15:0] line_unfinished;
  logic [15:0] frame_number;
  logic        frame_done;
  logic        vsync_late;
  logic        frame_busy;
  logic        frame_overrun;

  int checks   = 0;
  int failures = 0;

  sens_frame_progress #(
    .FRAME_HEIGHT_BITS(16),
    .LAST_FRAME_BITS  (16)
  ) dut (
    .mclk             (mclk),
    .rst_n            (rst_n),
    .en               (en),
    .frame_start      (frame_start),
    .line_done        (line_done),
    .frame_height     (frame_height),
    .vsync_delay      (vsync_delay),
    .last_frame_number(last_frame_number),
    .single_frame_buf (single_frame_buf),
    .line_unfinished  (line_unfinished),
    .frame_number     (frame_number),
    .frame_done       (frame_done),
    .vsync_late       (vsync_late),
    .frame_busy       (frame_busy),
    .frame_overrun    (frame_overrun)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // One line_done pulse followed by two idle cycles
  task automatic do_line();
    line_done = 1'b1;
    step();
    line_done = 1'b0;
    step();
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_line"}, line_unfinished, 0);
    check({tag, "_fnum"}, frame_number, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_vsync"}, vsync_late, 0);
    check({tag, "_busy"}, frame_busy, 0);
    check({tag, "_ovr"}, frame_overrun, 0);
  endtask

  // Full 4-line frame, then check the resulting buffer index
  task automatic run_frame(input string tag, input logic [15:0] exp_fn);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) do_line();
    check({tag, "_fnum"}, frame_number, exp_fn);
    check({tag, "_busy"}, frame_busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; frame_start = 1'b0; line_done = 1'b0;
    frame_height = 16'd4; vsync_delay = 16'd2; last_frame_number = 16'd3;
    single_frame_buf = 1'b0;
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check_all_zero("rst_release");

    // Normal frame
    en = 1'b1;
    step();
    line_done = 1'b1;
    step();
    line_done = 1'b0;
    check("ld_in_wait", line_unfinished, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("start_line", line_unfinished, 0);
    check("start_busy", frame_busy, 1);
    check("start_vsync", vsync_late, 0);
    for (int k = 1; k <= 4; k++) begin
      line_done = 1'b1;
      step();
      line_done = 1'b0;
      check($sformatf("nf_line%0d", k), line_unfinished, k);
      check($sformatf("nf_fnum%0d", k), frame_number, (k == 4) ? 1 : 0);
      check($sformatf("nf_busy%0d", k), frame_busy, (k < 4) ? 1 : 0);
      check($sformatf("nf_done_a%0d", k), frame_done, 0);
      check($sformatf("nf_vs_a%0d", k), vsync_late, 0);
      step();
      check($sformatf("nf_vs_b%0d", k), vsync_late, (k == 2) ? 1 : 0);
      check($sformatf("nf_done_b%0d", k), frame_done, (k == 4) ? 1 : 0);
      step();
      check($sformatf("nf_vs_c%0d", k), vsync_late, 0);
      check($sformatf("nf_done_c%0d", k), frame_done, 0);
    end
    check("nf_hold", line_unfinished, 4);

    // Overrun after 2 lines, with the vsync of the aborted frame still owed
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    do_line();
    line_done = 1'b1;
    step();
    line_done = 1'b0;
    check("ov_pre_line", line_unfinished, 2);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("ov_pulse", frame_overrun, 1);
    check("ov_line", line_unfinished, 0);
    check("ov_fnum", frame_number, 1);
    check("ov_vsync", vsync_late, 0);
    check("ov_busy", frame_busy, 1);
    check("ov_done", frame_done, 0);
    step();
    check("ov_pulse_end", frame_overrun, 0);
    check("ov_vsync2", vsync_late, 0);
    for (int i = 0; i < 3; i++) begin
      do_line();
      check($sformatf("ov_nodone%0d", i), frame_done, 0);
    end
    line_done = 1'b1;
    step();
    line_done = 1'b0;
    check("ov_last_fnum", frame_number, 2);
    check("ov_last_done", frame_done, 0);
    step();
    check("ov_done_pulse", frame_done, 1);
    step();

    // en dropped mid-frame together with a line_done
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    do_line();
    en = 1'b0;
    line_done = 1'b1;
    step();
    line_done = 1'b0;
    check_all_zero("en_off");
    en = 1'b1;
    step();

    // Wrap with last=1
    last_frame_number = 16'd1;
    run_frame("wrap1", 16'd1);
    run_frame("wrap2", 16'd0);
    run_frame("wrap3", 16'd1);

    // Single buffer
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    single_frame_buf = 1'b1;
    last_frame_number = 16'd3;
    run_frame("single1", 16'd0);
    run_frame("single2", 16'd0);
    run_frame("single3", 16'd0);
    single_frame_buf = 1'b0;

    // vsync_delay = 0
    vsync_delay = 16'd0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("d0_vs_a", vsync_late, 0);
    step();
    check("d0_vs_b", vsync_late, 1);
    step();
    check("d0_vs_c", vsync_late, 0);
    for (int i = 0; i < 4; i++) do_line();
    check("d0_fnum", frame_number, 1);

    // vsync_delay beyond frame height
    vsync_delay = 16'd10;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_line();
      check($sformatf("d10_novs%0d", i), vsync_late, 0);
    end
    line_done = 1'b1;
    step();
    line_done = 1'b0;
    check("d10_line", line_unfinished, 4);
    check("d10_vs_a", vsync_late, 0);
    check("d10_fnum", frame_number, 2);
    step();
    check("d10_vs_b", vsync_late, 1);
    check("d10_done_b", frame_done, 1);
    step();
    check("d10_vs_c", vsync_late, 0);

    // Zero-height frame_start ignored
    vsync_delay = 16'd2;
    frame_height = 16'd0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("h0_busy", frame_busy, 0);
    check("h0_line", line_unfinished, 4);
    line_done = 1'b1;
    step();
    line_done = 1'b0;
    check("h0_ld_line", line_unfinished, 4);
    frame_height = 16'd4;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("h4_busy", frame_busy, 1);
    check("h4_line", line_unfinished, 0);

    // Simultaneous frame_start and line_done
    do_line();
    check("sim_pre", line_unfinished, 1);
    frame_start = 1'b1;
    line_done = 1'b1;
    step();
    frame_start = 1'b0;
    line_done = 1'b0;
    check("sim_line", line_unfinished, 0);
    check("sim_ovr", frame_overrun, 1);

    // Asynchronous reset mid-frame
    do_line();
    check("rst_pre_busy", frame_busy, 1);
    rst_n = 1'b0;
    #2;
    check("arst_line", line_unfinished, 0);
    check("arst_busy", frame_busy, 0);
    check("arst_fnum", frame_number, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("arst_done%0d", i), frame_done, 0);
      check($sformatf("arst_ovr%0d", i), frame_overrun, 0);
    end
    rst_n = 1'b1;
    step();
    check_all_zero("arst_rel");
    step();
    check_all_zero("arst_rel2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sens_frame_progress
`default_nettype wire
